// File: rtl/fetch_align_pc_pkg.sv
// Shared constants, types and helpers for the realigning fetch stage.
package fetch_pkg;
    localparam int         ILEN     = 32;
    localparam int         HLEN     = 16;
    localparam logic [1:0] OPC_FULL = 2'b11;
    localparam int         PC_MAX_W = 64;

    // Where the instruction currently offered by the aligner comes from.
    typedef enum logic [2:0] {
        SRC_NONE,   // nothing deliverable
        SRC_H,      // compressed instruction held in the spill register
        SRC_HW,     // spill low half + W[15:0] forming a 32-bit instruction
        SRC_LO_C,   // compressed instruction in W[15:0]
        SRC_W32,    // aligned 32-bit instruction in W
        SRC_HI_C,   // compressed instruction in W[31:16]
        SRC_SPILL   // W[31:16] starts a 32-bit instruction: move it to H
    } align_src_e;

    typedef struct packed {
        logic [ILEN-1:0]     data;
        logic [PC_MAX_W-1:0] pc;
        logic                compr;
    } inst_pkt_t;

    function automatic logic is_compr(input logic [HLEN-1:0] half, input logic c_ext);
        return c_ext && (half[1:0] != OPC_FULL);
    endfunction
endpackage

// File: rtl/fetch_align_pc_if.sv
// Redirect, instruction-memory and instruction-delivery signals of the fetch stage.
interface fetch_align_pc_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_compr;
    logic [XLEN-1:0] pc_next;
    logic            misalign_err;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
               inst_compr, pc_next, misalign_err
    );

    // Environment side: pipeline control, memory and decode.
    modport slave (
        output redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
               inst_compr, pc_next, misalign_err
    );
endinterface

// File: rtl/fetch_align_pc_inst_align.sv
// Combinational instruction former: picks the next instruction out of the spill
// register and word buffer, or decides that the high half must be spilled.
module inst_align
    import fetch_pkg::*;
#(
    parameter int C_EXT = 1
) (
    input  logic [HLEN-1:0] h_i,
    input  logic            hv_i,
    input  logic [ILEN-1:0] w_i,
    input  logic            wv_i,
    input  logic            woff_i,
    output logic            valid_o,
    output logic [ILEN-1:0] data_o,
    output logic            compr_o,
    output align_src_e      src_o
);
    localparam logic CEXT_EN = (C_EXT != 0);

    // Spill register has priority; otherwise work through W by halfword offset.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        compr_o = 1'b0;
        src_o   = SRC_NONE;
        if (hv_i) begin
            if (is_compr(h_i, CEXT_EN)) begin
                valid_o = 1'b1;
                data_o  = {16'b0, h_i};
                compr_o = 1'b1;
                src_o   = SRC_H;
            end else if (wv_i) begin
                valid_o = 1'b1;
                data_o  = {w_i[15:0], h_i};
                src_o   = SRC_HW;
            end
        end else if (wv_i) begin
            if (!woff_i) begin
                valid_o = 1'b1;
                if (is_compr(w_i[15:0], CEXT_EN)) begin
                    data_o  = {16'b0, w_i[15:0]};
                    compr_o = 1'b1;
                    src_o   = SRC_LO_C;
                end else begin
                    data_o = w_i;
                    src_o  = SRC_W32;
                end
            end else if (is_compr(w_i[31:16], CEXT_EN)) begin
                valid_o = 1'b1;
                data_o  = {16'b0, w_i[31:16]};
                compr_o = 1'b1;
                src_o   = SRC_HI_C;
            end else begin
                src_o = SRC_SPILL;
            end
        end
    end
endmodule

// File: rtl/fetch_align_pc.sv
// IF stage: owns the fetch PC, issues word-aligned IMEM requests and realigns
// returned words into 16/32-bit instructions with their PC and return address.
module fetch_align_pc
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              C_EXT    = 1
) (
    input logic             clk,
    input logic             reset,
    fetch_align_pc_if.master bus
);
    logic [XLEN-1:0] faddr_q, faddr_d, cur_pc_q, cur_pc_d;
    logic [ILEN-1:0] w_q, w_d;
    logic [HLEN-1:0] h_q, h_d;
    logic            wv_q, wv_d, woff_q, woff_d, hv_q, hv_d;
    logic            out_pend_q, out_pend_d, drop_q, drop_d;

    logic            a_valid, a_compr, consume, w_free, req;
    logic [ILEN-1:0] a_data;
    logic [XLEN-1:0] pc_next_w;
    align_src_e      a_src;

    inst_align #(.C_EXT(C_EXT)) u_align (
        .h_i    (h_q),
        .hv_i   (hv_q),
        .w_i    (w_q),
        .wv_i   (wv_q),
        .woff_i (woff_q),
        .valid_o(a_valid),
        .data_o (a_data),
        .compr_o(a_compr),
        .src_o  (a_src)
    );

    // Handshake, request issue and PC increment; a redirect suppresses both.
    always_comb begin
        consume   = a_valid && bus.inst_ready && !bus.redirect_valid;
        // A spill or a final consumption empties W, so its refill can be requested now.
        w_free    = (consume && (a_src == SRC_W32 || a_src == SRC_HI_C))
                  || (a_src == SRC_SPILL && !bus.redirect_valid);
        req       = !out_pend_q && !bus.redirect_valid && (!wv_q || w_free)
                  && !(hv_q && !wv_q && out_pend_q);
        pc_next_w = cur_pc_q + (a_compr ? XLEN'(2) : XLEN'(4));
    end

    // Next-state for buffers, PCs and request tracking; redirect overrides all.
    always_comb begin
        faddr_d    = faddr_q;
        cur_pc_d   = cur_pc_q;
        w_d        = w_q;
        wv_d       = wv_q;
        woff_d     = woff_q;
        h_d        = h_q;
        hv_d       = hv_q;
        out_pend_d = out_pend_q;
        drop_d     = drop_q;
        if (bus.redirect_valid) begin
            wv_d       = 1'b0;
            hv_d       = 1'b0;
            cur_pc_d   = bus.redirect_pc;
            faddr_d    = bus.redirect_pc & ~XLEN'(3);
            woff_d     = bus.redirect_pc[1];
            drop_d     = out_pend_q && !bus.imem_rsp_valid;
            out_pend_d = out_pend_q && !bus.imem_rsp_valid;
        end else begin
            if (consume) begin
                cur_pc_d = pc_next_w;
                unique case (a_src)
                    SRC_H:    hv_d = 1'b0;
                    SRC_HW:   begin hv_d = 1'b0; woff_d = 1'b1; end
                    SRC_LO_C: woff_d = 1'b1;
                    SRC_W32,
                    SRC_HI_C: begin wv_d = 1'b0; woff_d = 1'b0; end
                    default:  ;
                endcase
            end
            if (a_src == SRC_SPILL) begin
                h_d    = w_q[31:16];
                hv_d   = 1'b1;
                wv_d   = 1'b0;
                woff_d = 1'b0;
            end
            if (bus.imem_rsp_valid) begin
                out_pend_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else begin
                    w_d  = bus.imem_rsp_data;
                    wv_d = 1'b1;
                end
            end
            if (req) begin
                faddr_d    = faddr_q + XLEN'(4);
                out_pend_d = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            faddr_q    <= RESET_PC & ~XLEN'(3);
            cur_pc_q   <= RESET_PC;
            woff_q     <= RESET_PC[1];
            wv_q       <= 1'b0;
            hv_q       <= 1'b0;
            out_pend_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            faddr_q    <= faddr_d;
            cur_pc_q   <= cur_pc_d;
            woff_q     <= woff_d;
            wv_q       <= wv_d;
            hv_q       <= hv_d;
            out_pend_q <= out_pend_d;
            drop_q     <= drop_d;
        end
    end

    // Data buffers are qualified by their valid flags and need no reset.
    always_ff @(posedge clk) begin
        w_q <= w_d;
        h_q <= h_d;
    end

    assign bus.imem_req_valid = req && !reset;
    assign bus.imem_req_addr  = reset ? '0 : faddr_q;
    assign bus.inst_valid     = a_valid && !reset;
    assign bus.inst_data      = reset ? '0 : a_data;
    assign bus.inst_pc        = reset ? '0 : cur_pc_q;
    assign bus.inst_compr     = a_compr && !reset;
    assign bus.pc_next        = reset ? '0 : pc_next_w;
    assign bus.misalign_err   = !reset && bus.redirect_valid
                              && (bus.redirect_pc[0] || ((C_EXT == 0) && bus.redirect_pc[1]));
endmodule

// File: tb/tb_fetch_align_pc.sv
// Bench for fetch_align_pc: 1-cycle-latency memory models, scoreboard queues of
// expected instructions, one task per scenario, plus a C_EXT = 0 instance.
module tb_fetch_align_pc;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        inst_pkt_t   pkt;
        logic [31:0] nxt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_align_pc_if #(.XLEN(32)) ifc ();
    fetch_align_pc_if #(.XLEN(32)) ifc0 ();

    fetch_align_pc #(.XLEN(32), .RESET_PC(32'h0), .C_EXT(1)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.master)
    );

    fetch_align_pc #(.XLEN(32), .RESET_PC(32'h0), .C_EXT(0)) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc0.master)
    );

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] mem0 [logic [31:0]];
    logic [31:0] req_log[$];
    logic [31:0] req_log0[$];
    exp_t        exp_q[$];
    exp_t        exp0_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for the C_EXT = 1 instance: answers exactly one cycle after a request.
    initial begin : mem_model
        logic        pv;
        logic [31:0] pa;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            pv = ifc.imem_req_valid;
            pa = ifc.imem_req_addr;
            if (pv) req_log.push_back(pa);
            #1;
            ifc.imem_rsp_valid = pv;
            ifc.imem_rsp_data  = pv ? (mem.exists(pa) ? mem[pa] : NOP) : 32'h0;
        end
    end

    // Memory for the C_EXT = 0 instance.
    initial begin : mem0_model
        logic        pv;
        logic [31:0] pa;
        ifc0.imem_rsp_valid = 1'b0;
        ifc0.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            pv = ifc0.imem_req_valid;
            pa = ifc0.imem_req_addr;
            if (pv) req_log0.push_back(pa);
            #1;
            ifc0.imem_rsp_valid = pv;
            ifc0.imem_rsp_data  = pv ? (mem0.exists(pa) ? mem0[pa] : NOP) : 32'h0;
        end
    end

    function automatic exp_t mk(input logic [31:0] d, input logic [31:0] pc,
                                input logic [31:0] nxt, input logic c);
        exp_t e;
        e.pkt.data  = d;
        e.pkt.pc    = PC_MAX_W'(pc);
        e.pkt.compr = c;
        e.nxt       = nxt;
        return e;
    endfunction

    task automatic hold_reset();
        reset               = 1'b1;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_pc     = '0;
        ifc.inst_ready      = 1'b1;
        ifc0.redirect_valid = 1'b0;
        ifc0.redirect_pc    = '0;
        ifc0.inst_ready     = 1'b1;
        mem.delete();
        mem0.delete();
        exp_q.delete();
        exp0_q.delete();
        repeat (2) @(posedge clk);
        req_log.delete();
        req_log0.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        #1;
        checks++;
        if ({ifc.imem_req_valid, ifc.inst_valid, ifc.inst_compr, ifc.misalign_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got req=%b val=%b compr=%b mis=%b want all 0",
                     ifc.imem_req_valid, ifc.inst_valid, ifc.inst_compr, ifc.misalign_err);
        end
        checks++;
        if ({ifc.imem_req_addr, ifc.inst_pc, ifc.pc_next, ifc.inst_data} !== 128'h0) begin
            errors++;
            $display("FAIL reset_buses got addr=%h pc=%h next=%h data=%h want 0",
                     ifc.imem_req_addr, ifc.inst_pc, ifc.pc_next, ifc.inst_data);
        end
        release_reset();
        #1;
        checks++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_request got valid=%b addr=%h want valid=1 addr=0",
                     ifc.imem_req_valid, ifc.imem_req_addr);
        end
    endtask

    task automatic test_aligned();
        exp_t e;
        hold_reset();
        mem[32'h0] = 32'h00A0_0093;
        mem[32'h4] = 32'h00B0_0113;
        exp_q.push_back(mk(32'h00A0_0093, 32'h0, 32'h4, 1'b0));
        exp_q.push_back(mk(32'h00B0_0113, 32'h4, 32'h8, 1'b0));
        release_reset();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.inst_valid && ifc.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL aligned got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL aligned_timeout got %0d pending want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        checks++;
        if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL aligned_reqs got n=%0d first=%h,%h,%h want 0,4,8", req_log.size(),
                     (req_log.size() > 0) ? req_log[0] : 32'hx, (req_log.size() > 1) ? req_log[1] : 32'hx,
                     (req_log.size() > 2) ? req_log[2] : 32'hx);
        end
    endtask

    task automatic test_compressed();
        exp_t e;
        hold_reset();
        mem[32'h0] = 32'h4501_4581;
        exp_q.push_back(mk(32'h0000_4581, 32'h0, 32'h2, 1'b1));
        exp_q.push_back(mk(32'h0000_4501, 32'h2, 32'h4, 1'b1));
        release_reset();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.inst_valid && ifc.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL compressed got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL compressed_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_spanning();
        exp_t e;
        hold_reset();
        mem[32'h0] = 32'h0093_4581;
        mem[32'h4] = 32'h4501_00A0;
        exp_q.push_back(mk(32'h0000_4581, 32'h0, 32'h2, 1'b1));
        exp_q.push_back(mk(32'h00A0_0093, 32'h2, 32'h6, 1'b0));
        exp_q.push_back(mk(32'h0000_4501, 32'h6, 32'h8, 1'b1));
        release_reset();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.inst_valid && ifc.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL spanning got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL spanning_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          accepted = 0;
        int          stall_cnt = 0;
        logic        have_snap = 1'b0;
        logic [96:0] snap;
        logic [96:0] now;
        hold_reset();
        mem[32'h00] = 32'h00A0_0093;
        mem[32'h04] = 32'h4501_4581;
        mem[32'h08] = 32'h0093_4581;
        mem[32'h0C] = 32'h4501_00A0;
        mem[32'h10] = 32'h00B0_0113;
        exp_q.push_back(mk(32'h00A0_0093, 32'h00, 32'h04, 1'b0));
        exp_q.push_back(mk(32'h0000_4581, 32'h04, 32'h06, 1'b1));
        exp_q.push_back(mk(32'h0000_4501, 32'h06, 32'h08, 1'b1));
        exp_q.push_back(mk(32'h0000_4581, 32'h08, 32'h0A, 1'b1));
        exp_q.push_back(mk(32'h00A0_0093, 32'h0A, 32'h0E, 1'b0));
        exp_q.push_back(mk(32'h0000_4501, 32'h0E, 32'h10, 1'b1));
        exp_q.push_back(mk(32'h00B0_0113, 32'h10, 32'h14, 1'b0));
        release_reset();
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            ifc.inst_ready = (accepted < 2) || (stall_cnt >= 5);
            @(negedge clk);
            checks++;
            if (ifc.imem_req_valid && ifc.imem_rsp_valid) begin
                errors++;
                $display("FAIL bp_outstanding got req while rsp pending want at most 1 outstanding");
            end
            now = {ifc.inst_valid, ifc.inst_data, ifc.inst_pc, ifc.pc_next};
            if (!ifc.inst_ready) begin
                stall_cnt++;
                if (have_snap) begin
                    checks++;
                    if (now !== snap) begin
                        errors++;
                        $display("FAIL bp_hold got %h want %h", now, snap);
                    end
                end else if (ifc.inst_valid) begin
                    snap      = now;
                    have_snap = 1'b1;
                end
            end
            if (ifc.inst_valid && ifc.inst_ready) begin
                accepted++;
                e = exp_q.pop_front();
                checks++;
                if ({ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL bp_stream got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        ifc.inst_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0 || stall_cnt != 5) begin
            errors++;
            $display("FAIL bp_timeout got pending=%0d stalls=%0d want 0 and 5", exp_q.size(), stall_cnt);
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        hold_reset();
        mem[32'h000] = 32'h00A0_0093;
        mem[32'h100] = 32'h4501_4581;
        mem[32'h104] = 32'h00B0_0113;
        exp_q.push_back(mk(32'h0000_4501, 32'h102, 32'h104, 1'b1));
        exp_q.push_back(mk(32'h00B0_0113, 32'h104, 32'h108, 1'b0));
        release_reset();
        // Redirect in the cycle the response to address 0 comes back.
        @(posedge clk);
        #1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h102;
        req_log.delete();
        @(negedge clk);
        checks++;
        if (ifc.misalign_err !== 1'b0 || ifc.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle got mis=%b req=%b want 0 0", ifc.misalign_err, ifc.imem_req_valid);
        end
        @(posedge clk);
        #1;
        ifc.redirect_valid = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.inst_valid && ifc.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL redirect got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc.inst_data, ifc.inst_pc, ifc.pc_next, ifc.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_timeout got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_req got n=%0d first=%h want 100", req_log.size(),
                     (req_log.size() > 0) ? req_log[0] : 32'hx);
        end
        @(posedge clk);
        #1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h101;
        @(negedge clk);
        checks++;
        if (ifc.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse got %b want 1", ifc.misalign_err);
        end
        @(posedge clk);
        #1;
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_end got %b want 0", ifc.misalign_err);
        end
    endtask

    task automatic test_no_cext();
        exp_t e;
        hold_reset();
        mem0[32'h0] = 32'h4501_4581;
        exp0_q.push_back(mk(32'h4501_4581, 32'h0, 32'h4, 1'b0));
        release_reset();
        for (int c = 0; c < 40 && exp0_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifc0.inst_valid && ifc0.inst_ready) begin
                e = exp0_q.pop_front();
                checks++;
                if ({ifc0.inst_data, ifc0.inst_pc, ifc0.pc_next, ifc0.inst_compr}
                    !== {e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr}) begin
                    errors++;
                    $display("FAIL no_cext got %h@%h next=%h c=%b want %h@%h next=%h c=%b",
                             ifc0.inst_data, ifc0.inst_pc, ifc0.pc_next, ifc0.inst_compr,
                             e.pkt.data, e.pkt.pc[31:0], e.nxt, e.pkt.compr);
                end
            end
        end
        checks++;
        if (exp0_q.size() != 0) begin
            errors++;
            $display("FAIL no_cext_timeout got %0d pending want 0", exp0_q.size());
        end
        @(posedge clk);
        #1;
        ifc0.redirect_valid = 1'b1;
        ifc0.redirect_pc    = 32'h2;
        @(negedge clk);
        checks++;
        if (ifc0.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL no_cext_misalign got %b want 1", ifc0.misalign_err);
        end
        @(posedge clk);
        #1;
        ifc0.redirect_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_aligned();
        test_compressed();
        test_spanning();
        test_backpressure();
        test_redirect();
        test_no_cext();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
